// File: rtl/dispatch_unit_if.sv
// Shared rename-packet type and the bundle of signals between dispatch and
// its neighbours (rename, ROB, reservation stations, writeback bus).
package dispatch_pkg;
   localparam int PREG_W = 7;
   localparam int ROB_W  = 5;

   typedef struct packed {
      logic [1:0]        fu;
      logic [6:0]        opcode;
      logic [PREG_W-1:0] pd_new;
      logic [PREG_W-1:0] ps1;
      logic [PREG_W-1:0] ps2;
      logic [31:0]       imm;
      logic [2:0]        func3;
      logic [6:0]        func7;
   } rename_data;
endpackage

interface dispatch_unit_if #(
   parameter int NUM_PREG = 128,
   parameter int PREG_W   = dispatch_pkg::PREG_W,
   parameter int ROB_W    = dispatch_pkg::ROB_W,
   parameter int CNT_W    = 32
);
   import dispatch_pkg::*;

   logic                rn_valid;
   logic                rn_ready;
   rename_data          r_data;
   logic                rob_full;
   logic [ROB_W-1:0]    rob_tail;
   logic                rob_alloc;
   logic [2:0]          rs_full;
   logic [2:0]          di_en;
   rename_data          di_data;
   logic [ROB_W-1:0]    di_rob_index;
   logic                wb_valid;
   logic [PREG_W-1:0]   wb_pd;
   logic                flush;
   logic [NUM_PREG-1:0] preg_rtable;
   logic [CNT_W-1:0]    dispatch_cnt;
   logic [CNT_W-1:0]    stall_cnt;

   // master is the dispatch unit itself; slave is everything around it
   modport master (
      input  rn_valid, r_data, rob_full, rob_tail, rs_full, wb_valid, wb_pd, flush,
      output rn_ready, rob_alloc, di_en, di_data, di_rob_index, preg_rtable,
             dispatch_cnt, stall_cnt
   );

   modport slave (
      output rn_valid, r_data, rob_full, rob_tail, rs_full, wb_valid, wb_pd, flush,
      input  rn_ready, rob_alloc, di_en, di_data, di_rob_index, preg_rtable,
             dispatch_cnt, stall_cnt
   );
endinterface

// File: rtl/dispatch_unit.sv
// One-entry dispatch stage: holds a renamed instruction, allocates its ROB
// entry, steers it to the ALU/branch/LSU station and owns the preg ready table.
module dispatch_unit
   import dispatch_pkg::*;
#(
   parameter int NUM_PREG = 128,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   dispatch_unit_if.master  dp
);

   typedef enum logic {EMPTY, HELD} state_t;

   state_t              state, state_next;
   rename_data          held_data;
   logic [1:0]          target_q, target_d;
   logic                fire, accept, load;
   logic [NUM_PREG-1:0] ready_table, table_next, wb_mask;
   logic [CNT_W-1:0]    dispatch_cnt_q, stall_cnt_q;

   // fu encoding 3 is an ALU op as well, so only 1 and 2 leave the ALU path
   always_comb begin
      target_d = 2'd0;
      if (dp.r_data.fu == 2'd1)
         target_d = 2'd1;
      else if (dp.r_data.fu == 2'd2)
         target_d = 2'd2;
   end

   assign fire     = (state == HELD) && !dp.rob_full && !dp.rs_full[target_q] && !dp.flush;
   assign accept   = dp.rn_valid && dp.rn_ready;
   assign dp.rn_ready     = ((state == EMPTY) || fire) && !dp.flush;
   assign dp.rob_alloc    = fire;
   assign dp.di_rob_index = dp.rob_tail;
   assign dp.di_data      = held_data;

   always_comb begin
      dp.di_en = 3'b000;
      if (fire)
         dp.di_en[target_q] = 1'b1;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      if (dp.flush) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_next = HELD;
                  load       = 1'b1;
               end
            end
            HELD: begin
               if (fire) begin
                  state_next = accept ? HELD : EMPTY;
                  load       = accept;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         held_data <= '0;
         target_q  <= 2'd0;
      end else begin
         state <= state_next;
         if (load) begin
            held_data <= dp.r_data;
            target_q  <= target_d;
         end
      end
   end

   // Clear is applied after set so a same-cycle writeback loses to the new allocation
   always_comb begin
      table_next = ready_table;
      if (dp.wb_valid)
         table_next[dp.wb_pd] = 1'b1;
      if (fire && (held_data.pd_new != '0))
         table_next[held_data.pd_new] = 1'b0;
      table_next[0] = 1'b1;
   end

   always_comb begin
      wb_mask = '0;
      if (dp.wb_valid)
         wb_mask[dp.wb_pd] = 1'b1;
   end

   // Bypass lets a station inserting this cycle see a same-cycle writeback
   assign dp.preg_rtable = ready_table | wb_mask;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ready_table <= '1;
      else
         ready_table <= table_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dispatch_cnt_q <= '0;
         stall_cnt_q    <= '0;
      end else begin
         if (fire)
            dispatch_cnt_q <= dispatch_cnt_q + CNT_W'(1);
         if ((state == HELD) && !fire && !dp.flush)
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign dp.dispatch_cnt = dispatch_cnt_q;
   assign dp.stall_cnt    = stall_cnt_q;

endmodule

// File: doc/dispatch_unit.md
Name: dispatch_unit

Overview:
- Stage between rename and the three reservation stations (ALU, branch, LSU).
- Buffers one renamed instruction and allocates a ROB entry for it.
- Routes the instruction to the target RS by FU class and drives that RS's dispatch enable.
- Owns the physical-register ready table that the RSs sample at insertion, and keeps a dispatch-stall performance counter.

Parameters:
- NUM_PREG, 128, number of physical registers.
- PREG_W, 7, physical register tag width.
- ROB_W, 5, ROB index width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- rn_valid  input  1  rename holds a valid instruction.
- rn_ready  output  1  dispatch can accept an instruction this cycle.
- r_data  input  rename_data  renamed instruction (fu, Opcode, pd_new, ps1, ps2, imm, func3, func7).
- rob_full  input  1  ROB cannot allocate.
- rob_tail  input  ROB_W  index the ROB will assign on allocation.
- rob_alloc  output  1  allocate a ROB entry this cycle.
- rs_full  input  3  per-RS full flags: [0] ALU, [1] branch, [2] LSU.
- di_en  output  3  one-hot dispatch enable per RS, same bit order.
- di_data  output  rename_data  held instruction, common to all RSs.
- di_rob_index  output  ROB_W  ROB index for the held instruction.
- wb_valid  input  1  a functional unit is writing back this cycle.
- wb_pd  input  PREG_W  destination tag of that writeback.
- flush  input  1  mispredict flush.
- preg_rtable  output  NUM_PREG  ready bit per physical register.
- dispatch_cnt  output  CNT_W  instructions dispatched.
- stall_cnt  output  CNT_W  cycles spent held and blocked.

Behaviour:
- State machine:
  - EMPTY: no instruction held.
  - HELD: holding one instruction, with di_data and a latched target.
- Target decode from r_data.fu: 0 → ALU, 1 → branch, 2 → LSU, 3 → ALU.
- fire = HELD && !rob_full && !rs_full[target] && !flush.
  - Combinational; di_en[target] = fire, all other bits 0.
  - rob_alloc = fire.
  - di_rob_index = rob_tail (combinational), so ROB and RS sample the same index on the fire edge.
- Handshake: rn_ready = (EMPTY || fire) && !flush. An accept happens when rn_valid && rn_ready.
- Transitions:
  - EMPTY + accept → HELD; capture r_data and its target.
  - HELD + fire + accept → HELD with the new instruction. Back-to-back throughput is 1 per cycle.
  - HELD + fire, no accept → EMPTY.
  - HELD, no fire → HELD; di_data stays stable.
  - flush in any state → EMPTY. The held instruction is dropped, with no di_en and no rob_alloc.
- Latency: rename accept at edge N → earliest di_en during cycle N+1, consumed at edge N+2.
- Ready table:
  - Reset sets every bit to 1.
  - Writeback: wb_valid sets bit wb_pd.
  - Dispatch: fire with pd_new != 0 clears bit pd_new.
  - Same preg set and cleared in one cycle: clear wins.
  - Bit 0 always reads 1.
  - flush does not modify the table.
- preg_rtable output = table OR (wb_valid ? onehot(wb_pd) : 0). A writeback in the same cycle as insertion is therefore seen by the RS, which does not wake entries it has not yet stored.
- Counters:
  - dispatch_cnt increments on fire.
  - stall_cnt increments when HELD && !fire && !flush.
  - Both wrap modulo 2^CNT_W.
- Reset (reset = 0), asynchronous and mid-operation included:
  - State → EMPTY; di_data → 0.
  - di_en = 0; rob_alloc = 0; rn_ready = 1 once reset deasserts.
  - Table → all 1.
  - Both counters → 0.

Test Plan:
- Reset, then one ALU instruction (ps1=5, ps2=6, pd_new=10, rob_tail=3); queues not full → di_en=3'b001 one cycle after accept, di_rob_index=3, rob_alloc=1; then preg_rtable[10]=0 and dispatch_cnt=1.
- Branch instruction held while rs_full[1]=1 for 4 cycles → di_en stays 0, rn_ready=0, stall_cnt=4; release rs_full → di_en=3'b010 next cycle.
- After pd=10 is cleared, wb_valid=1, wb_pd=10 in the same cycle a consumer with ps1=10 fires → preg_rtable[10]=1 that cycle and stays 1 afterward.
- Same cycle: fire allocating pd=20 and wb_pd=20 → preg_rtable bit 20 registers 0 (clear wins); a fire with pd_new=0 leaves bit 0 at 1.
- flush while HELD with an LSU instruction → no di_en and no rob_alloc; next cycle EMPTY with rn_ready=1; table unchanged.
- 8 back-to-back ALU instructions with no stalls → 8 consecutive cycles with di_en=001 and dispatch_cnt=8; assert reset=0 mid-stream → di_en=0 immediately, counters 0, every table bit 1.
